// File: rtl/clock_time_ctrl.sv
// Sequencing controller for the digital-clock counter chain: RUN-mode carry
// enables plus the time-set FSM with key single-step, auto-repeat and timeout.
module clock_time_ctrl #(
  parameter int unsigned REPEAT_START  = 8,
  parameter int unsigned REPEAT_PERIOD = 4,
  parameter int unsigned TIMEOUT_S     = 10,
  parameter int unsigned CW            = 16
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sec_tc,
  input  logic       min_tc,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] SET_HR  = 2'd1;
  localparam logic [1:0] SET_MIN = 2'd2;
  localparam logic [1:0] SET_SEC = 2'd3;

  localparam logic [CW-1:0] REP_START  = CW'(REPEAT_START);
  localparam logic [CW-1:0] REP_PERIOD = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT_S);

  logic [1:0]    state;
  logic [1:0]    stateNext;
  logic          prevMode;
  logic          prevInc;
  logic [CW-1:0] holdCnt;
  logic [CW-1:0] periodCnt;
  logic [CW-1:0] idleCnt;
  logic [CW-1:0] idleNext;

  logic modeEdge;
  logic incEdge;
  logic inSet;
  logic inRun;
  logic keyActive;
  logic repeatPulse;
  logic incPulse;
  logic timeout;
  logic stateChange;

  assign modeEdge  = key_mode & ~prevMode;
  assign incEdge   = key_inc & ~prevInc;
  assign inRun     = (state == RUN);
  assign inSet     = ~inRun;
  assign keyActive = key_mode | key_inc;

  // periodCnt only runs once the hold count has passed REP_START, so the
  // first repeat fires at REP_START and later ones every REP_PERIOD cycles.
  assign repeatPulse = key_inc &
                       ((holdCnt == REP_START) |
                        ((holdCnt > REP_START) & (periodCnt == REP_PERIOD)));

  // A simultaneous mode edge takes priority over any increment request.
  assign incPulse = inSet & (incEdge | repeatPulse) & ~modeEdge;

  assign idleNext = idleCnt + 1'b1;
  assign timeout  = inSet & tick_1hz & ~keyActive & (idleNext == IDLE_LIMIT);

  always_comb begin
    stateNext = state;
    if (modeEdge) begin
      stateNext = state + 2'd1;
    end else if (timeout) begin
      stateNext = RUN;
    end
  end

  assign stateChange = (stateNext != state);
  assign mode        = state;

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state    <= RUN;
      prevMode <= 1'b1;
      prevInc  <= 1'b1;
    end else begin
      state    <= stateNext;
      prevMode <= key_mode;
      prevInc  <= key_inc;
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      holdCnt   <= '0;
      periodCnt <= '0;
    end else if (!key_inc || stateChange) begin
      holdCnt   <= '0;
      periodCnt <= '0;
    end else begin
      if (holdCnt != '1) begin
        holdCnt <= holdCnt + 1'b1;
      end
      if (repeatPulse) begin
        periodCnt <= CW'(1);
      end else if ((holdCnt > REP_START) && (periodCnt != '1)) begin
        periodCnt <= periodCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      idleCnt <= '0;
    end else if (inRun || keyActive) begin
      idleCnt <= '0;
    end else if (tick_1hz) begin
      idleCnt <= idleNext;
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      sec_en  <= 1'b0;
      min_en  <= 1'b0;
      hr_en   <= 1'b0;
      sec_clr <= 1'b0;
      blink   <= 1'b0;
    end else begin
      sec_en  <= inRun & tick_1hz;
      min_en  <= (inRun & tick_1hz & sec_tc) |
                 (incPulse & (state == SET_MIN));
      hr_en   <= (inRun & tick_1hz & sec_tc & min_tc) |
                 (incPulse & (state == SET_HR));
      sec_clr <= incPulse & (state == SET_SEC);
      if (stateChange || inRun) begin
        blink <= 1'b0;
      end else if (tick_1hz) begin
        blink <= ~blink;
      end
    end
  end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: behavioural reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_clock_time_ctrl;

  localparam int RS = 8;
  localparam int RP = 4;
  localparam int TS = 10;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic       sec_tc = 1'b0;
  logic       min_tc = 1'b0;
  logic       sec_en, min_en, hr_en, sec_clr, blink;
  logic [1:0] mode;

  int total = 0;
  int bad = 0;

  clock_time_ctrl #(
    .REPEAT_START (RS),
    .REPEAT_PERIOD(RP),
    .TIMEOUT_S    (TS),
    .CW           (16)
  ) dut (
    .CP      (CP),
    .CR      (CR),
    .tick_1hz(tick_1hz),
    .key_mode(key_mode),
    .key_inc (key_inc),
    .sec_tc  (sec_tc),
    .min_tc  (min_tc),
    .sec_en  (sec_en),
    .min_en  (min_en),
    .hr_en   (hr_en),
    .sec_clr (sec_clr),
    .mode    (mode),
    .blink   (blink)
  );

  always #5 CP = ~CP;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mHeld = cycles key_inc has been held since the last clear,
  // mIdle = silent ticks seen in a set mode.
  int mState, mHeld, mIdle, mNext;
  bit mPrevMode, mPrevInc, mModeEdge, mIncEdge, mInc;
  bit mSecEn, mMinEn, mHrEn, mClr, mBlink;

  always @(posedge CP or posedge CR) begin
    if (CR) begin
      mState = 0; mHeld = 0; mIdle = 0;
      mPrevMode = 1; mPrevInc = 1;
      mSecEn = 0; mMinEn = 0; mHrEn = 0; mClr = 0; mBlink = 0;
    end else begin
      mModeEdge = key_mode && !mPrevMode;
      mIncEdge  = key_inc && !mPrevInc;
      mInc = key_inc && (mIncEdge || (mHeld >= RS && ((mHeld - RS) % RP) == 0));
      mSecEn = 0; mMinEn = 0; mHrEn = 0; mClr = 0;
      if (mState == 0) begin
        mSecEn = tick_1hz;
        mMinEn = tick_1hz && sec_tc;
        mHrEn  = tick_1hz && sec_tc && min_tc;
      end else if (mInc && !mModeEdge) begin
        case (mState)
          1: mHrEn = 1;
          2: mMinEn = 1;
          default: mClr = 1;
        endcase
      end
      if (mModeEdge) mNext = (mState + 1) % 4;
      else if (mState != 0 && tick_1hz && !key_mode && !key_inc && mIdle + 1 == TS) mNext = 0;
      else mNext = mState;
      if (mNext != mState || mState == 0) mBlink = 0;
      else if (tick_1hz) mBlink = !mBlink;
      if (mState == 0 || key_mode || key_inc) mIdle = 0;
      else if (tick_1hz) mIdle = mIdle + 1;
      if (mNext != mState || !key_inc) mHeld = 0;
      else mHeld = mHeld + 1;
      mPrevMode = key_mode;
      mPrevInc  = key_inc;
      mState = mNext;
    end
  end

  always @(negedge CP) begin
    if (!CR) begin
      check("model_sec_en", sec_en, mSecEn);
      check("model_min_en", min_en, mMinEn);
      check("model_hr_en", hr_en, mHrEn);
      check("model_sec_clr", sec_clr, mClr);
      check("model_mode", mode, mState);
      check("model_blink", blink, mBlink);
    end
  end

  task automatic pressMode(input int expMode);
    key_mode = 1'b1;
    @(negedge CP);
    check("press_mode", mode, expMode);
    key_mode = 1'b0;
    @(negedge CP);
  endtask

  task automatic tickMode(input int expMode);
    tick_1hz = 1'b1;
    @(negedge CP);
    check("tick_mode", mode, expMode);
    tick_1hz = 1'b0;
    @(negedge CP);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CP);
    check("reset_mode", mode, 0);
    check("reset_en", {sec_en, min_en, hr_en, sec_clr, blink}, 0);
    CR = 1'b0;
    @(negedge CP);

    // RUN carry chain
    sec_tc = 1'b1; min_tc = 1'b1; tick_1hz = 1'b1;
    @(negedge CP);
    check("carry_all", {sec_en, min_en, hr_en}, 3'b111);
    tick_1hz = 1'b0;
    @(negedge CP);
    check("carry_one_cycle", {sec_en, min_en, hr_en}, 3'b000);
    min_tc = 1'b0; tick_1hz = 1'b1;
    @(negedge CP);
    check("carry_no_hr", {sec_en, min_en, hr_en}, 3'b110);
    tick_1hz = 1'b0; sec_tc = 1'b0;
    @(negedge CP);

    // Mode cycling, halted timekeeping and blink
    pressMode(1);
    pressMode(2);
    tick_1hz = 1'b1;
    @(negedge CP);
    check("setmin_tick_en", {sec_en, min_en, hr_en}, 3'b000);
    check("blink_on", blink, 1);
    tick_1hz = 1'b0;
    @(negedge CP);
    pressMode(3);
    check("blink_mode_change", blink, 0);
    pressMode(0);
    check("blink_run", blink, 0);

    // Single step and auto-repeat in SET_HR
    pressMode(1);
    key_inc = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CP);
      check("repeat_hr", hr_en, (i == 1 || i == 9 || i == 13 || i == 17) ? 1 : 0);
    end
    key_inc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CP);
      check("repeat_released", hr_en, 0);
    end
    pressMode(2);
    pressMode(3);

    // SET_SEC clears seconds only
    key_inc = 1'b1;
    @(negedge CP);
    check("setsec_clr", {sec_clr, sec_en, min_en, hr_en}, 4'b1000);
    key_inc = 1'b0;
    @(negedge CP);
    check("setsec_clr_end", sec_clr, 0);
    pressMode(0);

    // Inactivity timeout
    pressMode(1);
    pressMode(2);
    for (int k = 1; k <= 10; k++) tickMode(k == 10 ? 0 : 2);
    pressMode(1);
    pressMode(2);
    for (int k = 1; k <= 5; k++) tickMode(2);
    key_inc = 1'b1;
    @(negedge CP);
    check("timeout_inc_min", min_en, 1);
    key_inc = 1'b0;
    @(negedge CP);
    for (int k = 1; k <= 10; k++) tickMode(k == 10 ? 0 : 2);

    // RUN tick coinciding with a mode edge still counts
    key_mode = 1'b1; tick_1hz = 1'b1;
    @(negedge CP);
    check("run_tick_mode_en", sec_en, 1);
    check("run_tick_mode", mode, 1);
    key_mode = 1'b0; tick_1hz = 1'b0;
    @(negedge CP);

    // Mode edge and inc edge together in SET_HR
    key_mode = 1'b1; key_inc = 1'b1;
    @(negedge CP);
    check("simul_mode", mode, 2);
    check("simul_no_hr", hr_en, 0);
    key_mode = 1'b0; key_inc = 1'b0;
    @(negedge CP);
    pressMode(3);
    pressMode(0);

    // Asynchronous reset mid-repeat
    pressMode(1);
    key_inc = 1'b1;
    repeat (9) @(negedge CP);
    check("pre_reset_hr", hr_en, 1);
    #2 CR = 1'b1;
    #1;
    check("async_reset_hr", hr_en, 0);
    check("async_reset_mode", mode, 0);
    repeat (2) @(negedge CP);
    CR = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CP);
      check("post_reset_no_pulse", {hr_en, min_en, sec_clr}, 0);
    end
    key_inc = 1'b0;
    repeat (2) @(negedge CP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Sequencing controller for the digital-clock counter chain. It generates the seconds, minutes and hours count enables from a 1 Hz tick and the counters' terminal-count flags. It also runs the time-set mode FSM driven by two debounced keys, including single-step, hold auto-repeat and inactivity timeout. It sits between the prescaler/key-debounce logic and the Counter6/Counter10/Counter24 instances, and drives their EN inputs.

## Interface
- REPEAT_START, 8: CP cycles key_inc must be held before the first auto-repeat pulse
- REPEAT_PERIOD, 4: CP cycles between subsequent auto-repeat pulses
- TIMEOUT_S, 10: tick_1hz pulses with no key activity before a set mode returns to RUN
- CW, 16: width of the internal hold and idle counters; must hold max(REPEAT_START, REPEAT_PERIOD, TIMEOUT_S)

- CP  in  1  system clock, all logic on the rising edge
- CR  in  1  reset, asynchronous, active-high
- tick_1hz  in  1  one-CP-cycle pulse once per second
- key_mode  in  1  debounced mode key, level, high = pressed
- key_inc  in  1  debounced increment key, level, high = pressed
- sec_tc  in  1  seconds counter at terminal value (59)
- min_tc  in  1  minutes counter at terminal value (59)
- sec_en  out  1  seconds counter count enable, one-cycle pulse
- min_en  out  1  minutes counter count enable, one-cycle pulse
- hr_en  out  1  hours counter count enable, one-cycle pulse
- sec_clr  out  1  synchronous clear request to the seconds counter, one-cycle pulse
- mode  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC
- blink  out  1  display blink phase for the selected field

## Operation
- Edge detect: key_mode and key_inc are each compared with a registered previous value. Previous-value registers reset to 1, so a key held through reset release produces no edge.
- FSM: a key_mode rising edge advances the state RUN→SET_HR→SET_MIN→SET_SEC→RUN. A timeout in any SET state returns to RUN.
- RUN:
  - sec_en = tick_1hz.
  - min_en = tick_1hz & sec_tc.
  - hr_en = tick_1hz & sec_tc & min_tc.
  - key_inc is ignored.
- SET states: timekeeping halts; tick_1hz produces no enables. An inc pulse (edge or auto-repeat) drives exactly one output:
  - SET_HR → hr_en.
  - SET_MIN → min_en. No carry into hours; min_tc is ignored.
  - SET_SEC → sec_clr.
- Auto-repeat: the hold counter clears when key_inc is low and counts CP cycles while it is high.
  - The first pulse comes from the rising edge.
  - The next pulse comes when the count reaches REPEAT_START.
  - Further pulses come every REPEAT_PERIOD cycles after that.
  - The hold counter saturates at its maximum instead of wrapping, and clears on any mode change.
- Timeout: the idle counter counts tick_1hz pulses in SET states only. It clears in any cycle where key_mode or key_inc is high, and in RUN. When it reaches TIMEOUT_S the state returns to RUN.
- Blink: toggles on each tick_1hz while in a SET state, held at 0 in RUN, and set to 0 on every state change.
- Simultaneous events:
  - key_mode edge together with key_inc activity: the mode change wins and the inc is dropped.
  - A tick in RUN in the same cycle as a mode edge: the tick's enables are still issued.
  - Timeout and a mode edge in the same cycle: the mode edge wins, because a pressed key clears the idle count.

## Timing
- All outputs are registered.
  - Enables and sec_clr appear one CP cycle after the causing input edge or tick.
  - mode updates one cycle after the key_mode edge.
- Every enable and sec_clr output is high for exactly one cycle per event.
- Reset values: sec_en=min_en=hr_en=sec_clr=0, mode=0 (RUN), blink=0, internal counters 0.
- Asserting CR mid-operation forces all outputs to their reset values immediately, regardless of CP. Operation resumes in RUN on the first CP edge after CR is deasserted.

## Test plan
- RUN carry chain: pulse tick_1hz with sec_tc=1, min_tc=1 → sec_en, min_en and hr_en all high one cycle later for exactly one cycle. Repeat with min_tc=0 → hr_en stays 0.
- Mode cycling: four key_mode presses → mode goes 1,2,3,0. A tick_1hz pulse in SET_MIN produces no enables. Blink toggles on ticks and is 0 back in RUN.
- Single step and repeat (REPEAT_START=8, REPEAT_PERIOD=4): in SET_HR hold key_inc for 20 cycles → hr_en pulses at cycles 1, 9, 13, 17 after the press, and no further pulses after release.
- SET_SEC: press key_inc → one sec_clr pulse; sec_en, min_en and hr_en stay 0.
- Timeout (TIMEOUT_S=10): enter SET_MIN, send 10 ticks with no keys → mode=0 after the 10th. Pressing key_inc after tick 5 restarts the count.
- Reset and simultaneity: assert CR mid-repeat → all outputs 0 immediately. Release CR with key_inc held → no pulse. key_mode and key_inc rising in the same cycle in SET_HR → mode=2, no hr_en.
